// File: rtl/rr_arbiter4_v_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
package rr_arbiter4_v_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned MAX_HOLD_DEF = 8;

endpackage

// File: rtl/rr_arbiter4_v_or4.sv
// Existing 4-input OR component, reused for the any-request term.
module OR4_v__cmpnt_self (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_y
);

  // Plain 4-input OR.
  always_comb begin
    o_y = i_a | i_b | i_c | i_d;
  end

endmodule

// File: rtl/rr_arbiter4_v.sv
// Round-robin arbiter: one-hot registered grant among four requesters,
// with a hold limit that forces rotation when others are waiting.
module rr_arbiter4_v
  import rr_arbiter4_v_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_id,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_preempt
);

  localparam int unsigned      CNT_W    = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_id;
  logic             r_preempt;

  logic       w_busy;
  logic       w_found;
  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic       w_owner_req;
  logic       w_others;

  OR4_v__cmpnt_self u_or4 (
    .i_a (i_req[0]),
    .i_b (i_req[1]),
    .i_c (i_req[2]),
    .i_d (i_req[3]),
    .o_y (w_busy)
  );

  // First set request searching from the priority pointer upward, mod 4.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = r_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Owner still requesting, and whether anyone else is waiting.
  always_comb begin
    w_owner_req = i_req[r_gnt_id];
    w_others    = |(i_req & ~r_gnt);
  end

  // Arbitration FSM: grant, hold counting, release and timeout rotation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_busy && w_found) begin
            r_gnt    <= 4'b0001 << w_pick;
            r_gnt_id <= w_pick;
            r_cnt    <= '0;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          // Release wins over timeout when both happen on the same edge.
          if (!w_owner_req) begin
            r_gnt   <= '0;
            r_ptr   <= r_gnt_id + 2'd1;
            r_state <= IDLE;
          end else if (r_cnt == CNT_LAST && w_others) begin
            r_gnt     <= '0;
            r_ptr     <= r_gnt_id + 2'd1;
            r_preempt <= 1'b1;
            r_state   <= IDLE;
          end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_gnt     = r_gnt;
    o_gnt_id  = r_gnt_id;
    o_valid   = |r_gnt;
    o_busy    = w_busy;
    o_preempt = r_preempt;
  end

endmodule

// File: tb/tb_rr_arbiter4_v.sv
// Self-checking bench for rr_arbiter4_v: reference model feeds a scoreboard,
// plus directed checks on grant order, hold length and reset behaviour.
module tb_rr_arbiter4_v;

  localparam int MH = 8;

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [3:0] i_req   = 4'b0000;
  logic [3:0] o_gnt;
  logic [1:0] o_gnt_id;
  logic       o_valid;
  logic       o_busy;
  logic       o_preempt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       pre;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] obs[$];
  logic       pre_obs[$];
  int         g_order[$];
  int         g_gaps[$];

  int   m_owner;
  int   m_ptr;
  int   m_cnt;
  logic m_pre;

  rr_arbiter4_v #(.MAX_HOLD(MH)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (i_req),
    .o_gnt     (o_gnt),
    .o_gnt_id  (o_gnt_id),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_preempt (o_preempt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_pre   = 1'b0;
  endtask

  // Next-state of the reference model for one clock edge with request vector req.
  task automatic model_step(input logic [3:0] req);
    logic [3:0] others;
    int c;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && req[c]) begin
          m_owner = c;
          m_cnt   = 0;
        end
      end
    end else begin
      others = req & ~(4'(1) << m_owner);
      if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else if (m_cnt == MH - 1 && others != 4'b0000) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_pre   = 1'b1;
      end else if (m_cnt < MH - 1) begin
        m_cnt++;
      end
    end
  endtask

  // Drive one cycle from a negedge, queue the expectation, compare after the edge.
  task automatic cyc(input logic [3:0] req);
    exp_t e;
    exp_t a;
    i_req = req;
    #1 check_val("busy", 32'(o_busy), 32'(|req));
    model_step(req);
    e.gnt   = (m_owner < 0) ? 4'b0000 : (4'(1) << m_owner);
    e.id    = (m_owner < 0) ? 2'd0 : 2'(m_owner);
    e.valid = (m_owner >= 0);
    e.pre   = m_pre;
    sb.push_back(e);
    @(posedge i_clk);
    #1;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL sb_underflow: got=empty exp=entry");
    end else begin
      a = sb.pop_front();
      check_val("gnt", 32'(o_gnt), 32'(a.gnt));
      check_val("valid", 32'(o_valid), 32'(a.valid));
      check_val("preempt", 32'(o_preempt), 32'(a.pre));
      if (a.valid) check_val("gnt_id", 32'(o_gnt_id), 32'(a.id));
    end
    obs.push_back(o_gnt);
    pre_obs.push_back(o_preempt);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    i_req   = 4'b0000;
    @(negedge i_clk);
    check_val("rst_gnt", 32'(o_gnt), 32'h0);
    check_val("rst_id", 32'(o_gnt_id), 32'h0);
    check_val("rst_valid", 32'(o_valid), 32'h0);
    check_val("rst_pre", 32'(o_preempt), 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    sb.delete();
    obs.delete();
    pre_obs.delete();
  endtask

  // Grant owners in order of appearance and the idle gap before each later grant.
  task automatic extract_order();
    int  zeros;
    bit  seen;
    g_order.delete();
    g_gaps.delete();
    zeros = 0;
    seen  = 0;
    foreach (obs[i]) begin
      if (obs[i] == 4'b0000) begin
        zeros++;
      end else if (i == 0 || obs[i-1] != obs[i]) begin
        g_order.push_back($clog2(int'(obs[i])));
        if (seen) g_gaps.push_back(zeros);
        seen  = 1;
        zeros = 0;
      end
    end
  endtask

  function automatic int count_pre();
    int n = 0;
    foreach (pre_obs[i]) if (pre_obs[i]) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_order[5];
    logic [3:0] r;
    int guard;
    int run;
    model_reset();

    // Idle after reset.
    do_reset();
    repeat (5) cyc(4'b0000);

    // Single requester holds indefinitely without preemption.
    do_reset();
    cyc(4'b0100);
    check_val("single_gnt", 32'(o_gnt), 32'h4);
    check_val("single_id", 32'(o_gnt_id), 32'h2);
    repeat (20) cyc(4'b0100);
    check_val("single_nopre", 32'(count_pre()), 32'h0);
    cyc(4'b0000);
    check_val("single_drop", 32'(o_gnt), 32'h0);

    // Fairness: each owner drops after three grant cycles, reasserts next cycle.
    do_reset();
    repeat (25) begin
      r = 4'b1111;
      for (int k = 0; k < 4; k++) if (m_owner == k && m_cnt == 2) r[k] = 1'b0;
      cyc(r);
    end
    extract_order();
    exp_order = '{0, 1, 2, 3, 0};
    check_val("fair_count", 32'(g_order.size() >= 5), 32'h1);
    for (int i = 0; i < 5 && i < g_order.size(); i++)
      check_val("fair_order", 32'(g_order[i]), 32'(exp_order[i]));
    foreach (g_gaps[i]) check_val("fair_gap", 32'(g_gaps[i]), 32'h1);

    // Timeout rotation between requesters 0 and 1.
    do_reset();
    repeat (40) cyc(4'b0011);
    extract_order();
    check_val("to_count", 32'(g_order.size() >= 3), 32'h1);
    if (g_order.size() >= 3) begin
      check_val("to_order0", 32'(g_order[0]), 32'h0);
      check_val("to_order1", 32'(g_order[1]), 32'h1);
      check_val("to_order2", 32'(g_order[2]), 32'h0);
    end
    run = 0;
    while (run < obs.size() && obs[run] == 4'b0001) run++;
    check_val("to_hold_len", 32'(run), 32'(MH));
    check_val("to_pre_at", 32'(pre_obs[MH]), 32'h1);
    check_val("to_pre_count", 32'(count_pre()), 32'h4);

    // Release coinciding with timeout counts as release only.
    do_reset();
    cyc(4'b0010);
    guard = 0;
    while (m_owner == 1 && guard < 20) begin
      cyc((m_cnt == MH - 1) ? 4'b1000 : 4'b1010);
      guard++;
    end
    cyc(4'b1000);
    check_val("sim_next", 32'(o_gnt), 32'h8);
    check_val("sim_nopre", 32'(count_pre()), 32'h0);

    // Asynchronous reset mid-grant, then pointer restarts at 0.
    do_reset();
    cyc(4'b1000);
    cyc(4'b1000);
    check_val("ar_pre_gnt", 32'(o_gnt), 32'h8);
    #2 i_rst_n = 1'b0;
    #1;
    check_val("ar_gnt", 32'(o_gnt), 32'h0);
    check_val("ar_valid", 32'(o_valid), 32'h0);
    check_val("ar_id", 32'(o_gnt_id), 32'h0);
    check_val("ar_busy", 32'(o_busy), 32'h1);
    model_reset();
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cyc(4'b1001);
    check_val("ar_first", 32'(o_gnt), 32'h1);
    repeat (4) cyc(4'b1001);

    // Random traffic against the model.
    repeat (80) cyc(4'($urandom_range(0, 15)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
